// File: rtl/instr_mem_loader.sv
// instr_mem_loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] word_count,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [1:0] r_lane;
  logic w_xfer;
  logic w_accept;
  assign w_xfer = byte_valid && byte_ready;
  assign w_accept = (r_state == IDLE) && start && |word_count;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = start ? (|word_count ? RECV : DONE) : IDLE;
      RECV:  w_next = (w_xfer && r_lane == 2'd3) ? WRITE : RECV;
      WRITE: w_next = (r_cnt == ADDR_WIDTH'(1)) ? DONE : RECV;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // Outputs are registered from the next state so each one tracks the FSM without a decode stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      byte_ready <= w_next == RECV;
      mem_we     <= w_next == WRITE;
      cpu_hold   <= w_next == RECV || w_next == WRITE;
      busy       <= w_next == RECV || w_next == WRITE;
      done       <= w_next == DONE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      r_cnt     <= '0;
      r_lane    <= '0;
    end else if (w_accept) begin
      mem_addr <= BASE_ADDR;
      r_cnt    <= word_count;
      r_lane   <= '0;
    end else if (r_state == RECV && w_xfer) begin
      mem_wdata[{r_lane, 3'b000} +: 8] <= byte_in;
      r_lane <= r_lane + 2'd1;
    end else if (r_state == WRITE) begin
      mem_addr <= mem_addr + ADDR_WIDTH'(4);
      r_cnt    <= r_cnt - ADDR_WIDTH'(1);
      r_lane   <= '0;
    end
  end
endmodule
